// File: rtl/led_mmio_if.sv
// Data-memory side bus between the core's load/store port and the LED peripheral.
interface led_mmio_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, we, wstrb, wdata, input  rdata, sel);
  modport slave  (input  addr, we, wstrb, wdata, output rdata, sel);
endinterface

// File: rtl/led_mmio.sv
// Memory-mapped LED peripheral: static, blink and rotate modes paced by a
// programmable prescaler. Register file is 8 words at BASE_ADDR.
module led_mmio #(
  parameter int unsigned LED_W          = 18,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  led_mmio_if.slave        bus,
  output logic [LED_W-1:0] led_out
);

  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_ROT   = 2'd2;

  typedef enum logic [2:0] {
    OFF_DATA   = 3'd0,
    OFF_SET    = 3'd1,
    OFF_CLR    = 3'd2,
    OFF_CTRL   = 3'd3,
    OFF_PERIOD = 3'd4,
    OFF_STATUS = 3'd5,
    OFF_RSV6   = 3'd6,
    OFF_RSV7   = 3'd7
  } off_e;

  logic             hit, wr;
  off_e             off;
  logic [31:0]      bmask, wmasked;
  logic             wr_data, wr_set, wr_clr, wr_ctrl, wr_period;
  logic             restart, wrap;
  logic [31:0]      eff_m1;

  logic [LED_W-1:0] data_q, data_d, data_rot;
  logic [1:0]       ctrl_q;
  logic [31:0]      period_q, cnt_q;
  logic             phase_q, tick_q;

  // Byte-within-word address bits play no part in decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr[1:0];

  assign hit     = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign off     = off_e'(bus.addr[4:2]);
  assign bus.sel = hit;
  assign wr      = bus.we & hit;

  assign wr_data   = wr && (off == OFF_DATA);
  assign wr_set    = wr && (off == OFF_SET);
  assign wr_clr    = wr && (off == OFF_CLR);
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_period = wr && (off == OFF_PERIOD);

  // Any CTRL/PERIOD store restarts the prescaler and blink phase.
  assign restart = wr_ctrl | wr_period;

  // PERIOD of 0 behaves as 1: terminal count is 0 in both cases.
  assign eff_m1 = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
  assign wrap   = !restart && (cnt_q == eff_m1);

  // Expand byte strobes into a bit mask.
  always_comb begin
    bmask = '0;
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{bus.wstrb[i]}};
  end
  assign wmasked = bus.wdata & bmask;

  generate
    if (LED_W == 1) begin : g_rot1
      assign data_rot = data_q;
    end else begin : g_rotn
      assign data_rot = {data_q[LED_W-2:0], data_q[LED_W-1]};
    end
  endgenerate

  // Next DATA: a software store beats the rotate step on the same edge.
  always_comb begin
    data_d = data_q;
    if (wr_data)
      data_d = (data_q & ~bmask[LED_W-1:0]) | wmasked[LED_W-1:0];
    else if (wr_set)
      data_d = data_q | wmasked[LED_W-1:0];
    else if (wr_clr)
      data_d = data_q & ~wmasked[LED_W-1:0];
    else if (wrap && (ctrl_q == MODE_ROT))
      data_d = data_rot;
  end

  // Software-visible registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      period_q <= DEFAULT_PERIOD;
    end else begin
      data_q <= data_d;
      if (wr_ctrl && bus.wstrb[0]) ctrl_q <= bus.wdata[1:0];
      if (wr_period) period_q <= (period_q & ~bmask) | wmasked;
    end
  end

  // Prescaler: tick is the registered wrap pulse; phase only moves in blink.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else if (restart) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
      if (ctrl_q == MODE_BLINK) phase_q <= ~phase_q;
    end else begin
      cnt_q  <= cnt_q + 32'd1;
      tick_q <= 1'b0;
    end
  end

  // Load data mux; everything outside the window reads 0.
  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      unique case (off)
        OFF_DATA:   bus.rdata = 32'(data_q);
        OFF_CTRL:   bus.rdata = {30'b0, ctrl_q};
        OFF_PERIOD: bus.rdata = period_q;
        OFF_STATUS: bus.rdata = {30'b0, phase_q, tick_q};
        default:    bus.rdata = '0;
      endcase
    end
  end

  assign led_out = ((ctrl_q == MODE_BLINK) && phase_q) ? '0 : data_q;

endmodule

// File: tb/tb_led_mmio.sv
// Bench for led_mmio: directed plan items plus random bus traffic, checked
// per cycle against a cycle-count based reference model via a scoreboard.
module tb_led_mmio;
  localparam int          W     = 18;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] DEFP  = 32'd25_000_000;
  localparam logic [31:0] LMASK = (32'h1 << W) - 32'h1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] led_out;

  led_mmio_if bus();

  led_mmio #(.LED_W(W), .BASE_ADDR(BASE), .DEFAULT_PERIOD(DEFP)) dut (
    .clk(clk), .rst(rst), .bus(bus), .led_out(led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [W-1:0] led;
    logic        sel;
    logic [31:0] rdata;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    n_chk  = 0;
  int    n_fail = 0;
  string tag    = "reset";

  // Reference state: registers plus number of edges since the last restart.
  logic [31:0] m_data, m_period;
  logic [1:0]  m_ctrl;
  longint      m_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic longint eff();
    return (m_period == 0) ? 64'd1 : longint'(m_period);
  endfunction

  task automatic model_reset();
    m_data = 0; m_ctrl = 0; m_period = DEFP; m_s = 0;
  endtask

  // Outputs the DUT should present now, given the current address.
  function automatic exp_t model_out(input logic [31:0] a);
    exp_t   e;
    longint ef = eff();
    logic   ph, tk;
    ph = (m_ctrl == 2'd1) && (((m_s / ef) % 2) == 1);
    tk = (m_s > 0) && ((m_s % ef) == 0);
    e.tag   = tag;
    e.sel   = (a[31:5] == BASE[31:5]);
    e.led   = ph ? '0 : m_data[W-1:0];
    e.rdata = 0;
    if (e.sel) begin
      case (a[4:2])
        3'd0: e.rdata = m_data;
        3'd3: e.rdata = {30'b0, m_ctrl};
        3'd4: e.rdata = m_period;
        3'd5: e.rdata = {30'b0, ph, tk};
        default: e.rdata = 0;
      endcase
    end
    return e;
  endfunction

  // State change at the coming rising edge.
  task automatic model_edge(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic        wr;
    logic [2:0]  o;
    logic [31:0] bm, dm;
    logic        rs, wp;
    longint      ef = eff();
    wr = w && (a[31:5] == BASE[31:5]);
    o  = a[4:2];
    bm = bytemask(s);
    dm = d & bm;
    rs = wr && (o == 3'd3 || o == 3'd4);
    wp = !rs && ((m_s % ef) == ef - 1);
    if (wr && o == 3'd0)      m_data = ((m_data & ~bm) | dm) & LMASK;
    else if (wr && o == 3'd1) m_data = (m_data | dm) & LMASK;
    else if (wr && o == 3'd2) m_data = m_data & ~dm & LMASK;
    else if (wp && m_ctrl == 2'd2)
      m_data = ((m_data << 1) | (m_data >> (W - 1))) & LMASK;
    if (wr && o == 3'd3 && s[0]) m_ctrl = d[1:0];
    if (wr && o == 3'd4) m_period = (m_period & ~bm) | dm;
    m_s = rs ? 0 : m_s + 1;
  endtask

  // One bus cycle: drive, queue the expected response, advance the model.
  task automatic step(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(posedge clk); #1;
    bus.we = w; bus.addr = a; bus.wstrb = s; bus.wdata = d;
    q.push_back(model_out(a));
    model_edge(w, a, s, d);
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s = 4'hF);
    step(1'b1, BASE + 32'(o), s, d);
  endtask

  task automatic rd(input logic [7:0] o);
    step(1'b0, BASE + 32'(o), 4'h0, 32'h0);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk); #1;
    bus.we = 1'b0; bus.addr = BASE + 32'h10; bus.wstrb = 0; bus.wdata = 0;
    rst = 1'b0;
    #1;
    chk({name, "_led"}, 32'(led_out), 32'h0);
    chk({name, "_period"}, bus.rdata, DEFP);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_edge(1'b0, bus.addr, 4'h0, 32'h0);
  endtask

  // Scoreboard monitor: one expected entry per presented cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk({mon_e.tag, "_led"}, 32'(led_out), 32'(mon_e.led));
      chk({mon_e.tag, "_sel"}, 32'(bus.sel), 32'(mon_e.sel));
      chk({mon_e.tag, "_rdata"}, bus.rdata, mon_e.rdata);
    end
  end

  initial begin
    bus.we = 0; bus.addr = BASE + 32'h10; bus.wstrb = 0; bus.wdata = 0;
    model_reset();
    #20;
    @(negedge clk);
    chk("reset_led", 32'(led_out), 32'h0);
    rst = 1'b1;
    model_edge(1'b0, bus.addr, 4'h0, 32'h0);
    rd(8'h10); rd(8'h0C); rd(8'h00);

    tag = "static";
    wr(8'h00, 32'h2A5A5); rd(8'h00);
    wr(8'h00, 32'hFF, 4'b0001); rd(8'h00);

    tag = "setclr";
    wr(8'h00, 32'hF0); wr(8'h04, 32'h0F); rd(8'h00);
    wr(8'h08, 32'hF0); rd(8'h00); rd(8'h04); rd(8'h08);

    tag = "blink";
    wr(8'h10, 32'd4); wr(8'h00, 32'h3); wr(8'h0C, 32'd1);
    repeat (13) rd(8'h14);
    wr(8'h10, 32'd4);
    repeat (9) rd(8'h14);

    tag = "rotate";
    wr(8'h10, 32'd2); wr(8'h00, 32'h20000); wr(8'h0C, 32'd2);
    repeat (6) rd(8'h14);
    while ((m_s % eff()) != eff() - 1) rd(8'h14);
    wr(8'h00, 32'h15555);
    repeat (4) rd(8'h00);

    tag = "period1";
    wr(8'h10, 32'd1); wr(8'h00, 32'h5); wr(8'h0C, 32'd1);
    repeat (5) rd(8'h14);
    tag = "period0";
    wr(8'h10, 32'd0);
    repeat (5) rd(8'h14);

    tag = "decode";
    wr(8'h0C, 32'd3); wr(8'h00, 32'h1234);
    step(1'b1, BASE + 32'h20, 4'hF, 32'h3FFFF); rd(8'h00);
    step(1'b0, BASE + 32'h20, 4'h0, 32'h0);
    step(1'b1, BASE + 32'h1, 4'hF, 32'h111); rd(8'h00);
    wr(8'h18, 32'hFFFF_FFFF); rd(8'h18); rd(8'h1C); rd(8'h00);
    wr(8'h14, 32'hFFFF_FFFF); rd(8'h14);

    tag = "midrst";
    wr(8'h10, 32'd3); wr(8'h00, 32'h1F); wr(8'h0C, 32'd2);
    repeat (5) rd(8'h14);
    async_reset("midrst");
    rd(8'h10); rd(8'h00); rd(8'h0C);

    tag = "random";
    wr(8'h10, 32'd3);
    for (int i = 0; i < 500; i++) begin
      int unsigned r, o;
      logic [31:0] a, d;
      r = $urandom_range(0, 9);
      o = $urandom_range(0, 7);
      a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
      if (r == 0) a = a + 32'h20;
      if (r == 1) a = a - 32'h20;
      d = $urandom;
      if (o == 4) d = 32'($urandom_range(0, 5));
      step(r < 6, a, 4'($urandom_range(0, 15)), d);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mmio.md
Name: led_mmio

Overview:
- Memory-mapped LED peripheral directly downstream of the RV32I single-cycle core's data-memory store/load port.
- Drives the 18 board LEDs (LEDR[17:0]) from software-written registers.
- Supports three display modes, all paced by a programmable prescaler:
  - static
  - hardware blink
  - hardware rotate ("running light")
- Sits between the core's data bus decode and the top-level LEDR pins.

Parameters:
- LED_W, 18: number of LED outputs (1..32).
- BASE_ADDR, 32'h1000_0000: peripheral base; 32-byte aligned.
- DEFAULT_PERIOD, 25_000_000: reset value of PERIOD (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from core ALU result.
- we  in  1  store request this cycle.
- wstrb  in  4  byte enables for store; wstrb[i] covers wdata[8i+7:8i].
- wdata  in  32  store data.
- rdata  out  32  load data, combinational.
- sel  out  1  high when addr[31:5]==BASE_ADDR[31:5]; the core muxes rdata on it.
- led_out  out  LED_W  LED drive, active-high.

Behaviour:
- Decode: hit = sel; offset = addr[4:2]. A write occurs on a rising edge when we && hit. Misaligned addr[1:0] is ignored (word offset only).
- Register map:
  - 0x00 DATA RW [LED_W-1:0]
  - 0x04 SET W1S, reads 0
  - 0x08 CLR W1C, reads 0
  - 0x0C CTRL RW [1:0] mode: 0 static, 1 blink, 2 rotate, 3 treated as static
  - 0x10 PERIOD RW [31:0]
  - 0x14 STATUS RO {30'b0, phase, tick}
  - 0x18/0x1C read 0, writes ignored
- Byte enables: DATA/CTRL/PERIOD update only enabled bytes. SET/CLR act on (wdata masked by wstrb expanded per byte). Bits at or above LED_W are dropped.
- Reset (rst low, async):
  - DATA=0, CTRL=0, PERIOD=DEFAULT_PERIOD, cnt=0, phase=0, tick=0
  - led_out=0, rdata=0 when not hit
  - Mid-operation reset clears everything immediately, without waiting for a clock edge.
- Prescaler:
  - cnt increments every cycle.
  - When cnt == eff-1, where eff = (PERIOD==0 ? 1 : PERIOD), cnt goes to 0 and tick pulses high for exactly that one cycle.
  - tick is registered, asserted the cycle after cnt wraps.
  - In mode 0 the prescaler keeps running, but tick has no effect.
- Restart: a write to CTRL or PERIOD forces cnt=0 and phase=0 on the same edge. No tick is produced on that edge.
- Blink (mode 1): phase toggles on each tick. led_out = phase ? 0 : DATA.
- Rotate (mode 2): on each tick, DATA <= {DATA[LED_W-2:0], DATA[LED_W-1]}. led_out = DATA.
- Static (mode 0/3): led_out = DATA.
- led_out is a combinational function of registered DATA/CTRL/phase. A store is therefore visible on led_out immediately after its write edge (0 extra cycles).
- Simultaneous rotate tick and software write to DATA/SET/CLR: the software write wins, and the rotate step is dropped for that tick.
- Read: rdata = selected register when hit (regardless of we), else 0. Unwritten bits read 0.
- PERIOD written to 1: tick every cycle; blink toggles every cycle.

Test Plan:
- Reset: hold rst=0 20 ns, release → led_out=0, read 0x10 = DEFAULT_PERIOD, read 0x0C = 0.
- Static store: write 0x00 = 0x2A5A5, wstrb=4'hF → led_out=18'h2A5A5 after that edge. Then write wstrb=4'b0001, wdata=0xFF → led_out=18'h2A5FF.
- SET/CLR: DATA=0x00F0, write 0x04=0x000F → 0x00FF. Then write 0x08=0x00F0 → 0x000F. Reading 0x04 returns 0.
- Blink: PERIOD=4, DATA=0x3, CTRL=1.
  - led_out alternates 0x3 / 0x0, with each level lasting exactly 4 clk cycles.
  - Writing PERIOD mid-count restarts the phase with led_out=0x3.
- Rotate wrap: PERIOD=2, DATA=18'h20000, CTRL=2.
  - After 2 cycles led_out=18'h00001; after 4 cycles 18'h00002.
  - A DATA write coincident with a tick loads the written value unrotated.
- Decode: write to BASE_ADDR+0x20 → no sel, DATA unchanged, rdata=0. PERIOD=0 behaves as 1 (tick every cycle).
